// File: rtl/prod_accum.sv
// Frame accumulator behind the 4x4 multiplier: sums 8-bit products with a sticky
// saturating clamp and hands the frame sum, beat count and saturation flag downstream.
module prod_accum #(
    parameter int ACC_W   = 12,
    parameter int MAX_LEN = 16,
    parameter int CNT_W   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_prod,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_sat
);

    typedef enum logic {ACCUM = 1'b0, DONE = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic [ACC_W-1:0] out_sum_q, out_sum_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic             out_sat_q, out_sat_d;

    logic             accept;
    logic             close;
    logic             hit;
    logic [ACC_W-1:0] nsum;
    logic [CNT_W-1:0] cnt_inc;

    // MSB of the result flags an overflow; the low bits are already clamped to all-ones.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a, input logic [7:0] p);
        logic [ACC_W:0] wide;
        wide = {1'b0, a} + (ACC_W+1)'(p);
        if (wide[ACC_W]) begin
            return {1'b1, {ACC_W{1'b1}}};
        end
        return wide;
    endfunction

    assign accept          = in_valid & in_ready;
    assign {hit, nsum}     = sat_add(acc_q, in_prod);
    assign cnt_inc         = cnt_q + CNT_W'(1);
    assign close           = accept & (in_last | (cnt_inc == CNT_W'(MAX_LEN)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   if (close) state_d = DONE;
            DONE:    if (out_ready) state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    // in_ready is gated by rst_n so nothing is offered while reset is held.
    always_comb begin
        in_ready  = rst_n & (state_q == ACCUM);
        out_valid = (state_q == DONE);
    end

    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        sat_d     = sat_q;
        out_sum_d = out_sum_q;
        out_cnt_d = out_cnt_q;
        out_sat_d = out_sat_q;
        if (close) begin
            out_sum_d = nsum;
            out_cnt_d = cnt_inc;
            out_sat_d = sat_q | hit;
            acc_d     = '0;
            cnt_d     = '0;
            sat_d     = 1'b0;
        end else if (accept) begin
            acc_d = nsum;
            cnt_d = cnt_inc;
            sat_d = sat_q | hit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
            out_sum_q <= '0;
            out_cnt_q <= '0;
            out_sat_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            sat_q     <= sat_d;
            out_sum_q <= out_sum_d;
            out_cnt_q <= out_cnt_d;
            out_sat_q <= out_sat_d;
        end
    end

    assign out_sum = out_sum_q;
    assign out_cnt = out_cnt_q;
    assign out_sat = out_sat_q;

endmodule

// File: doc/prod_accum.md
Name: prod_accum

Overview:
- Sequential accumulator stage directly downstream of the team's combinational 4x4 array multiplier (multi_4bit).
- Consumes one 8-bit product per handshake and sums products over a frame.
- A frame ends on in_last or after MAX_LEN products; the registered frame sum, beat count and saturation flag are then presented on a valid/ready output.
- Turns the multiplier into a dot-product / MAC datapath.

Parameters:
- ACC_W, 12, accumulator and out_sum width; must be >= 8. The default holds 16*225 = 3600 without saturation.
- MAX_LEN, 16, maximum products per frame; the frame auto-closes when this count is reached; must be >= 1.
- CNT_W, 5, beat-counter width; must hold MAX_LEN.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, in_prod/in_last valid this cycle.
- in_ready, output, 1, block accepts a product this cycle.
- in_prod, input, 8, unsigned product from multiplier out[7:0].
- in_last, input, 1, the accepted product is the final one of its frame.
- out_valid, output, 1, frame result available.
- out_ready, input, 1, downstream accepts the result.
- out_sum, output, ACC_W, unsigned frame sum, saturated.
- out_cnt, output, CNT_W, number of products in the frame (1..MAX_LEN).
- out_sat, output, 1, saturation occurred at least once in the frame.

Behaviour:
- Reset, asynchronous on rst_n low:
  - state = ACCUM; acc, count, out_sum, out_cnt = 0.
  - out_sat, sat_flag, out_valid = 0.
  - in_ready = 1 once rst_n is high.
- Two-state FSM: ACCUM, DONE.
- ACCUM state:
  - in_ready = 1, out_valid = 0.
  - On in_valid & in_ready (accept): nsum = acc + zero-extended in_prod.
    - If nsum > 2^ACC_W-1, nsum is clamped to 2^ACC_W-1 and sat_flag is set.
    - acc <= nsum; count <= count+1.
  - The frame closes when the accepted beat has in_last = 1 OR count+1 == MAX_LEN.
  - On close:
    - out_sum <= nsum, out_cnt <= count+1, out_sat <= sat_flag | (this beat saturated).
    - out_valid <= 1; state <= DONE.
    - acc, count and sat_flag clear to 0 in the same edge.
  - in_valid with no accept has no effect. in_last is ignored unless in_valid = 1.
- DONE state:
  - in_ready = 0, out_valid = 1.
  - out_sum, out_cnt and out_sat are held stable while out_ready = 0 (no change under backpressure).
  - On out_ready = 1: out_valid <= 0, state <= ACCUM. in_ready rises the following cycle; there is no same-cycle bypass.
- Latency:
  - The result is visible the cycle after the closing beat is accepted.
  - Throughput is one product per cycle within a frame, plus a minimum 1-cycle bubble per frame (the DONE cycle).
- Arithmetic:
  - Unsigned only.
  - The clamp is sticky: once saturated, acc stays at max for the rest of the frame.
  - No wrap-around is ever permitted.
- Count boundary: count never exceeds MAX_LEN-1 in ACCUM; the MAX_LEN-th beat always closes the frame.
- in_last and the MAX_LEN auto-close on the same beat produce one close; out_cnt = MAX_LEN.
- Single-beat frame (in_last on the first beat): out_sum = in_prod, out_cnt = 1.
- The out_* registers hold their last value after handshake, while out_valid = 0.
- Reset mid-frame or while in DONE:
  - The partial frame is discarded.
  - out_valid drops immediately (asynchronous).
  - No result is emitted for the aborted frame.

Test Plan:
- Reset then a frame of products 6, 20, 225 with in_last on the third, out_ready = 1 -> out_valid 1 cycle after the third accept; out_sum = 251, out_cnt = 3, out_sat = 0; in_ready low for exactly 1 cycle.
- 16 consecutive products of 225, no in_last, MAX_LEN = 16 -> auto-close with out_sum = 3600, out_cnt = 16, out_sat = 0; the 17th product starts a new frame whose result is out_sum = that product alone.
- ACC_W = 10; products 225 x5, last on the fifth -> out_sum = 1023, out_sat = 1, out_cnt = 5; the next frame 1, 2 (last) -> out_sum = 3, out_sat = 0.
- Result pending with out_ready held low 7 cycles, in_valid held high with varying in_prod -> out_sum/out_cnt stable, in_ready = 0, no product consumed; after out_ready the held in_prod is accepted as beat 1 of the next frame.
- Single-beat frame in_prod = 0x00 with in_last -> out_sum = 0, out_cnt = 1; then in_prod = 0xE1 with in_last -> out_sum = 225, out_cnt = 1.
- Assert rst_n low after 2 beats (9, 9) of a frame, release, then send 4 (last) -> out_sum = 4, out_cnt = 1; out_valid never asserted for the aborted frame.
